// File: rtl/muldiv_rv_m_defs_pkg.sv
// RV32M shared definitions: funct3 op codes and the mul/div FSM state encoding.
// Shared by the decoder and the iterative multiply/divide unit.
// Helper predicates classify an op by its funct3 bits.
package rv_m_defs;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned STEPS = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

  // Divide family lives in the upper half of the funct3 space.
  function automatic logic is_div_op(input logic [2:0] f3);
    return f3[2];
  endfunction

  // REM/REMU return the remainder rather than the quotient.
  function automatic logic is_rem_op(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  // Whether rs1 is interpreted as signed.
  function automatic logic a_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  // Whether rs2 is interpreted as signed.
  function automatic logic b_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply / restoring divide.
// Latency: 34 cycles from start to wb_we; divide-by-zero and signed overflow finish in 1.
// Backpressure: start is only honoured in IDLE; requests while busy are dropped, not queued.
module muldiv_unit
  import rv_m_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data
);

  mdu_state_t  state;
  logic [2:0]  op;
  logic [4:0]  rd_q;
  logic [4:0]  cnt;
  logic        neg;
  // prod doubles as {remainder, quotient/dividend} during division.
  logic [63:0] prod;
  // Multiplicand for multiply, divisor magnitude for divide.
  logic [31:0] opnd;

  logic        sa, sb;
  logic [31:0] a_mag, b_mag;
  logic        neg_in;
  logic        div_in, rem_in, div_by_zero, sgn_ovf;
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_trial;
  logic [63:0] prod_neg;
  logic [31:0] quo_fix, rem_fix, result;

  // Capture-side operand conditioning: magnitudes and result sign for the request.
  always_comb begin
    sa          = a_signed(funct3) & op_a[31];
    sb          = b_signed(funct3) & op_b[31];
    a_mag       = sa ? (32'd0 - op_a) : op_a;
    b_mag       = sb ? (32'd0 - op_b) : op_b;
    div_in      = is_div_op(funct3);
    rem_in      = is_rem_op(funct3);
    div_by_zero = div_in && (op_b == 32'd0);
    sgn_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                  (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
    neg_in      = 1'b0;
    case (funct3)
      F3_MULH, F3_DIV: neg_in = sa ^ sb;
      F3_MULHSU, F3_REM: neg_in = sa;
      default: neg_in = 1'b0;
    endcase
  end

  // One iteration of each datapath plus the final sign fix-up and result select.
  always_comb begin
    mul_sum   = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, opnd} : 33'd0);
    div_shift = {prod[63:32], prod[31]};
    div_trial = div_shift - {1'b0, opnd};
    prod_neg  = neg ? (64'd0 - prod) : prod;
    quo_fix   = neg ? (32'd0 - prod[31:0]) : prod[31:0];
    rem_fix   = neg ? (32'd0 - prod[63:32]) : prod[63:32];
    result    = 32'd0;
    case (op)
      F3_MUL:                       result = prod[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result = prod_neg[63:32];
      F3_DIV, F3_DIVU:              result = quo_fix;
      default:                      result = rem_fix;
    endcase
  end

  // Control FSM with registered outputs; reset wins over any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      op      <= 3'd0;
      rd_q    <= 5'd0;
      cnt     <= 5'd0;
      neg     <= 1'b0;
      prod    <= 64'd0;
      opnd    <= 32'd0;
      busy    <= 1'b0;
      wb_we   <= 1'b0;
      wb_rd   <= 5'd0;
      wb_data <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op   <= funct3;
            rd_q <= rd_in;
            cnt  <= 5'd0;
            busy <= 1'b1;
            if (div_by_zero) begin
              state   <= S_DONE;
              wb_we   <= 1'b1;
              wb_rd   <= rd_in;
              wb_data <= rem_in ? op_a : 32'hFFFF_FFFF;
            end else if (sgn_ovf) begin
              state   <= S_DONE;
              wb_we   <= 1'b1;
              wb_rd   <= rd_in;
              wb_data <= rem_in ? 32'd0 : 32'h8000_0000;
            end else begin
              state <= S_CALC;
              neg   <= neg_in;
              prod  <= div_in ? {32'd0, a_mag} : {32'd0, b_mag};
              opnd  <= div_in ? b_mag : a_mag;
            end
          end
        end
        S_CALC: begin
          if (is_div_op(op)) begin
            if (!div_trial[32]) prod <= {div_trial[31:0], prod[30:0], 1'b1};
            else                prod <= {div_shift[31:0], prod[30:0], 1'b0};
          end else begin
            prod <= {mul_sum, prod[31:1]};
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'(STEPS - 1)) state <= S_FIX;
        end
        S_FIX: begin
          state   <= S_DONE;
          wb_we   <= 1'b1;
          wb_rd   <= rd_q;
          wb_data <= result;
        end
        default: begin
          state <= S_IDLE;
          wb_we <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
// Drives on the falling edge, samples on the falling edge.
// Latency counts the falling edges from the start-sampling edge to the wb_we sample.
module tb_muldiv_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  muldiv_unit dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .rd_in   (rd_in),
    .busy    (busy),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and wait (bounded) for its write-back pulse; lat = -1 on timeout.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] data,
                        output logic [4:0] rdo, output int lat);
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b; rd_in = rd;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!wb_we && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (!wb_we) lat = -1;
    data = wb_data;
    rdo  = wb_rd;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", wb_we); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0d want 0", wb_rd); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", wb_data); end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [31:0] d; logic [4:0] r; int lat;
    run_op(rv_m_defs::F3_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, d, r, lat);
    checks++; if (d !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_data got %h want ffffffeb", d); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL mul_latency got %0d want 34", lat); end
    checks++; if (r !== 5'd5) begin errors++; $display("FAIL mul_rd got %0d want 5", r); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mul_busy_in_done got %b want 1", busy); end
    @(negedge clk);
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL mul_we_pulse got %b want 0", wb_we); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_after got %b want 0", busy); end
    checks++; if (wb_data !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_hold got %h want ffffffeb", wb_data); end
  endtask

  task automatic test_mulh();
    logic [31:0] d; logic [4:0] r; int lat;
    run_op(rv_m_defs::F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, d, r, lat);
    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mulhu got %h want fffffffe", d); end
    run_op(rv_m_defs::F3_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, d, r, lat);
    checks++; if (d !== 32'h0000_0000) begin errors++; $display("FAIL mulh_m1 got %h want 00000000", d); end
    run_op(rv_m_defs::F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd7, d, r, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulhsu got %h want ffffffff", d); end
    run_op(rv_m_defs::F3_MULH, 32'h8000_0000, 32'h8000_0000, 5'd8, d, r, lat);
    checks++; if (d !== 32'h4000_0000) begin errors++; $display("FAIL mulh_min got %h want 40000000", d); end
    run_op(rv_m_defs::F3_MULH, 32'hFFFF_FFFE, 32'd3, 5'd8, d, r, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mulh_neg got %h want ffffffff", d); end
  endtask

  task automatic test_div();
    logic [31:0] d; logic [4:0] r; int lat;
    run_op(rv_m_defs::F3_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, d, r, lat);
    checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg got %h want fffffffd", d); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
    run_op(rv_m_defs::F3_REM, 32'hFFFF_FFF9, 32'd2, 5'd9, d, r, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rem_neg got %h want ffffffff", d); end
    run_op(rv_m_defs::F3_DIVU, 32'd100, 32'd7, 5'd10, d, r, lat);
    checks++; if (d !== 32'd14) begin errors++; $display("FAIL divu got %h want 0000000e", d); end
    run_op(rv_m_defs::F3_REMU, 32'd100, 32'd7, 5'd10, d, r, lat);
    checks++; if (d !== 32'd2) begin errors++; $display("FAIL remu got %h want 00000002", d); end
    run_op(rv_m_defs::F3_DIV, 32'd7, 32'hFFFF_FFFE, 5'd11, d, r, lat);
    checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negdivisor got %h want fffffffd", d); end
    run_op(rv_m_defs::F3_REM, 32'd7, 32'hFFFF_FFFE, 5'd11, d, r, lat);
    checks++; if (d !== 32'd1) begin errors++; $display("FAIL rem_posdividend got %h want 00000001", d); end
    run_op(rv_m_defs::F3_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd0, d, r, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divu_max got %h want ffffffff", d); end
    checks++; if (r !== 5'd0) begin errors++; $display("FAIL rd_zero got %0d want 0", r); end
  endtask

  task automatic test_special();
    logic [31:0] d; logic [4:0] r; int lat;
    run_op(rv_m_defs::F3_DIV, 32'd100, 32'd0, 5'd12, d, r, lat);
    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div0 got %h want ffffffff", d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency got %0d want 1", lat); end
    checks++; if (r !== 5'd12) begin errors++; $display("FAIL div0_rd got %0d want 12", r); end
    run_op(rv_m_defs::F3_REMU, 32'd100, 32'd0, 5'd13, d, r, lat);
    checks++; if (d !== 32'h0000_0064) begin errors++; $display("FAIL remu0 got %h want 00000064", d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL remu0_latency got %0d want 1", lat); end
    run_op(rv_m_defs::F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, d, r, lat);
    checks++; if (d !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf got %h want 80000000", d); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL div_ovf_latency got %0d want 1", lat); end
    run_op(rv_m_defs::F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, d, r, lat);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL rem_ovf got %h want 00000000", d); end
    run_op(rv_m_defs::F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, d, r, lat);
    checks++; if (d !== 32'd0) begin errors++; $display("FAIL divu_no_ovf got %h want 00000000", d); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL divu_no_ovf_latency got %0d want 34", lat); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] d; logic [4:0] r; int lat; int pulses;
    @(negedge clk);
    start = 1'b1; funct3 = rv_m_defs::F3_MUL; op_a = 32'd9; op_b = 32'd9; rd_in = 5'd16;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (wb_we !== 1'b0) begin errors++; $display("FAIL abort_we got %b want 0", wb_we); end
    reset = 1'b0; start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wb_we) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_we got %0d pulses want 0", pulses); end
    run_op(rv_m_defs::F3_MUL, 32'd3, 32'd4, 5'd17, d, r, lat);
    checks++; if (d !== 32'd12) begin errors++; $display("FAIL post_abort_mul got %h want 0000000c", d); end
  endtask

  task automatic test_busy_ignore();
    int pulses; logic [31:0] d; logic [4:0] r;
    @(negedge clk);
    start = 1'b1; funct3 = rv_m_defs::F3_DIVU; op_a = 32'd100; op_b = 32'd7; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; funct3 = rv_m_defs::F3_MUL; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; d = 32'd0; r = 5'd0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (wb_we) begin pulses++; d = wb_data; r = wb_rd; end
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_ignore_pulses got %0d want 1", pulses); end
    checks++; if (d !== 32'd14) begin errors++; $display("FAIL busy_ignore_data got %h want 0000000e", d); end
    checks++; if (r !== 5'd3) begin errors++; $display("FAIL busy_ignore_rd got %0d want 3", r); end
  endtask

  task automatic test_done_start();
    logic [31:0] d; logic [4:0] r; int lat; int pulses;
    run_op(rv_m_defs::F3_DIV, 32'd100, 32'd0, 5'd1, d, r, lat);
    // Now sampling the DONE cycle: a start presented here must be dropped.
    start = 1'b1; funct3 = rv_m_defs::F3_MUL; op_a = 32'd3; op_b = 32'd5; rd_in = 5'd2;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (wb_we) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL done_start_ignored got %0d pulses want 0", pulses); end
    checks++; if (wb_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL done_hold_data got %h want ffffffff", wb_data); end
    checks++; if (wb_rd !== 5'd1) begin errors++; $display("FAIL done_hold_rd got %0d want 1", wb_rd); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_reset_abort();
    test_busy_ignore();
    test_done_start();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
